// File: rtl/alu_issue_arbiter_if.sv
// Requester-side bus of the ALU issue arbiter: packed request lanes, one-hot
// grant and the shared response bus.
interface alu_issue_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [4*NUM_REQ-1:0]     req_opcode;
  logic [WIDTH*NUM_REQ-1:0] req_a;
  logic [WIDTH*NUM_REQ-1:0] req_b;
  logic                     rsp_valid;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_result;
  logic [3:0]               rsp_flags;

  modport slave (
    input  req_valid, req_opcode, req_a, req_b,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
  );

  modport master (
    output req_valid, req_opcode, req_a, req_b,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
  );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter sharing one pipelined ALU between NUM_REQ clients;
// a tag pipeline matched to the ALU latency routes each result back to its requester.
module alu_issue_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 8,
  parameter int ALU_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_issue_en,
  alu_issue_arbiter_if.slave bus,
  output logic [3:0]        o_alu_opcode,
  output logic [WIDTH-1:0]  o_alu_input1,
  output logic [WIDTH-1:0]  o_alu_input2,
  output logic [4:0]        o_alu_shiftValue,
  input  logic [WIDTH-1:0]  i_alu_result,
  input  logic              i_alu_carry,
  input  logic              i_alu_zero,
  input  logic              i_alu_overflow,
  input  logic              i_alu_sign,
  output logic              o_busy
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0]     r_ptr;
  logic [IDW-1:0]     w_ptr_nxt;
  logic [IDW-1:0]     w_gnt_idx;
  logic               w_gnt_any;
  logic [NUM_REQ-1:0] w_gnt;

  logic [3:0]         r_alu_opcode;
  logic [WIDTH-1:0]   r_alu_input1;
  logic [WIDTH-1:0]   r_alu_input2;

  logic [ALU_LATENCY:0] r_tag_vld;
  logic [IDW-1:0]       r_tag_id [ALU_LATENCY+1];

  logic               r_rsp_valid;
  logic [IDW-1:0]     r_rsp_id;
  logic [WIDTH-1:0]   r_rsp_result;
  logic [3:0]         r_rsp_flags;

  // Search starts at ptr and wraps; grants are suppressed during reset too.
  always_comb begin : p_arb
    logic [IDW-1:0] idx;
    idx       = '0;
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_gnt_any = 1'b0;
    w_ptr_nxt = r_ptr;
    if (rst_n && i_issue_en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = IDW'((int'(r_ptr) + k) % NUM_REQ);
        if (!w_gnt_any && bus.req_valid[idx]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = idx;
          w_gnt[idx] = 1'b1;
          w_ptr_nxt = IDW'((int'(idx) + 1) % NUM_REQ);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr        <= '0;
      r_alu_opcode <= '0;
      r_alu_input1 <= '0;
      r_alu_input2 <= '0;
    end else if (w_gnt_any) begin
      r_ptr        <= w_ptr_nxt;
      r_alu_opcode <= bus.req_opcode[4*w_gnt_idx +: 4];
      r_alu_input1 <= bus.req_a[WIDTH*w_gnt_idx +: WIDTH];
      r_alu_input2 <= bus.req_b[WIDTH*w_gnt_idx +: WIDTH];
    end
  end

  // Tag stage s lines up with the ALU having seen the operand for s edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld <= '0;
      for (int s = 0; s <= ALU_LATENCY; s++) r_tag_id[s] <= '0;
    end else begin
      r_tag_vld   <= {r_tag_vld[ALU_LATENCY-1:0], w_gnt_any};
      r_tag_id[0] <= w_gnt_idx;
      for (int s = 1; s <= ALU_LATENCY; s++) r_tag_id[s] <= r_tag_id[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
    end else if (r_tag_vld[ALU_LATENCY]) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_id     <= r_tag_id[ALU_LATENCY];
      r_rsp_result <= i_alu_result;
      r_rsp_flags  <= {i_alu_carry, i_alu_zero, i_alu_overflow, i_alu_sign};
    end else begin
      r_rsp_valid  <= 1'b0;
    end
  end

  assign bus.req_ready    = w_gnt;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_id       = r_rsp_id;
  assign bus.rsp_result   = r_rsp_result;
  assign bus.rsp_flags    = r_rsp_flags;
  assign o_alu_opcode     = r_alu_opcode;
  assign o_alu_input1     = r_alu_input1;
  assign o_alu_input2     = r_alu_input2;
  assign o_alu_shiftValue = '0;
  assign o_busy           = (|r_tag_vld) | r_rsp_valid;
endmodule

// File: doc/alu_issue_arbiter.md
# alu_issue_arbiter

Round-robin arbiter and sequencer that shares one pipelined 8-bit ALU between NUM_REQ requesters. It accepts at most one operation per cycle through valid/ready handshakes and drives the ALU's opcode and operand inputs from registers. It tracks each in-flight operation in a tag pipeline and returns the ALU result and flags to the originating requester on a shared response bus. It sits between client blocks and the ALU instance; the integration inverts rst_n for the ALU's active-high rst.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- WIDTH, 8: operand/result width; must match the ALU
- ALU_LATENCY, 2: clock edges from a change on alu_* outputs to the corresponding ALU result/flags being valid
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- issue_en  in  1  1 = grants allowed; 0 = no new grants, in-flight operations drain
- req_valid  in  NUM_REQ  per-requester request valid
- req_opcode  in  4*NUM_REQ  opcode, requester i at [4i+3:4i]
- req_a  in  WIDTH*NUM_REQ  operand 1, packed the same way
- req_b  in  WIDTH*NUM_REQ  operand 2, packed the same way
- req_ready  out  NUM_REQ  one-hot grant, combinational
- alu_opcode  out  4  registered opcode to ALU
- alu_input1  out  WIDTH  registered operand 1 to ALU
- alu_input2  out  WIDTH  registered operand 2 to ALU
- alu_shiftValue  out  5  tied 0
- alu_result  in  WIDTH  ALU result
- alu_carry, alu_zero, alu_overflow, alu_sign  in  1 each  ALU flags
- rsp_valid  out  1  registered response strobe, one cycle
- rsp_id  out  $clog2(NUM_REQ)  originating requester index
- rsp_result  out  WIDTH  captured result
- rsp_flags  out  4  {carry, zero, overflow, sign}, captured
- busy  out  1  1 while any operation is in flight or rsp_valid is high

## Operation
- Arbitration: round-robin pointer ptr. With issue_en=1, req_ready[i]=1 for the first i with req_valid[i]=1, searching ptr, ptr+1, ... mod NUM_REQ. At most one bit is set. With issue_en=0, req_ready is all zero.
- req_ready depends combinationally on req_valid. A requester must not make req_valid depend on req_ready.
- Transfer happens when req_valid[i] & req_ready[i] at a rising edge. On that edge:
  - alu_opcode, alu_input1, alu_input2 load requester i's fields;
  - a tag {1, i} enters stage 0 of the tag pipeline;
  - ptr becomes (i+1) mod NUM_REQ.
- No transfer: alu_* keep their values, a tag {0, x} enters stage 0, and ptr holds.
- Tag pipeline: ALU_LATENCY+1 stages, shifting every cycle, no stall. When the final stage holds a valid tag, the next edge registers rsp_valid=1, rsp_id, rsp_result=alu_result and rsp_flags from the ALU inputs. Otherwise rsp_valid=0 and rsp_id/result/flags hold.
- Responses have no backpressure. Consumers must accept rsp_valid on every cycle it is asserted.
- Opcodes pass through unmodified, including ALU-reserved codes. Results are returned exactly as the ALU produces them; the arbiter does no arithmetic.
- busy = OR of all valid tag bits | rsp_valid.

## Timing
- Reset (rst_n=0, asynchronous): ptr=0; all tags invalid; alu_opcode=0, alu_input1=0, alu_input2=0; rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0; busy=0. req_ready is all zero while rst_n=0.
- Reset mid-operation discards all in-flight operations. No response is ever produced for them.
- Latency: a transfer at edge E0 gives rsp_valid high in the cycle following edge E0+ALU_LATENCY+1, which is 3 cycles after acceptance with the default parameters.
- Throughput: one acceptance per cycle. Responses come back in acceptance order, one per cycle.
- issue_en deasserted blocks grants in the same cycle (combinational). Operations already accepted still complete.
- A requester holding req_valid continuously with all others also requesting is granted once every NUM_REQ cycles.

## Test plan
- Single request: requester 2 sends ADD a=8'h05, b=8'h03 with all others idle. Required: req_ready=4'b0100 in the same cycle; 3 cycles later rsp_valid=1, rsp_id=2, rsp_result=8'h08, carry=0; busy=0 on the following cycle.
- Full contention: all 4 requesters hold valid with ptr=0 for 8 cycles. Required grant order 0,1,2,3,0,1,2,3; responses carry rsp_id in the same order on consecutive cycles.
- Back-to-back mixed ops: SUB 8'h03-8'h05 on requester 0, then MUL 8'h04*8'h03 on requester 1, in consecutive cycles. Required: rsp_result 8'hFE with carry=1, then 8'h0C with rsp_id=1, on consecutive cycles.
- issue_en=0 with req_valid=4'b1111. Required: req_ready=0 and no new responses; in-flight responses still appear. Reasserting issue_en resumes granting from the stored ptr.
- Reset mid-flight: assert rst_n=0 for one cycle, one cycle after two acceptances. Required: all outputs return to reset values immediately and no rsp_valid appears for the discarded operations.
- Round-robin skip: only requesters 1 and 3 are valid, with ptr=2. Required grants are 3 then 1, and ptr=2 afterwards.
